// File: rtl/acc_result_drain.sv
// -----------------------------------------------------------------------------
// acc_result_drain
//
// Output-side consumer of the accumulator array. Lane results arrive diagonally
// skewed (lane i runs i cycles behind lane 0), so every lane gets its own FIFO
// that soaks up the skew and any writeback backpressure. Once a tile has been
// announced with calc_done_i, full rows are popped from all lane FIFOs at once
// and handed downstream over a valid/ready handshake. drain_done_o pulses after
// the announced number of rows has been accepted.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   lane_valid_i      per-lane write strobe for data_in
//   data_in           per-lane result words
//   calc_done_i       tile announcement pulse
//   valid_depth_i     rows in the tile minus one (sampled with calc_done_i)
//   is_init_data_i    tile tag (sampled with calc_done_i)
//   row_valid_o       aligned row presented
//   row_ready_i       downstream accepts the row
//   row_data_o        aligned row; element i is the head of lane FIFO i
//   row_idx_o         index of the presented row within the tile
//   row_last_o        presented row is the final row of the tile
//   is_init_data_o    latched tile tag
//   drain_done_o      one-cycle pulse after the last row handshake
//   busy_o            high while a tile is in progress
//   overflow_o        sticky: a lane write was dropped
//   protocol_err_o    sticky: calc_done_i arrived while a tile was in progress
// -----------------------------------------------------------------------------
module acc_result_drain #(
    parameter int unsigned SIZE       = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SIZE-1:0]           lane_valid_i,
    input  logic [DATA_WIDTH-1:0]     data_in [0:SIZE-1],
    input  logic                      calc_done_i,
    input  logic [$clog2(SIZE)-1:0]   valid_depth_i,
    input  logic                      is_init_data_i,
    output logic                      row_valid_o,
    input  logic                      row_ready_i,
    output logic [DATA_WIDTH-1:0]     row_data_o [0:SIZE-1],
    output logic [$clog2(SIZE)-1:0]   row_idx_o,
    output logic                      row_last_o,
    output logic                      is_init_data_o,
    output logic                      drain_done_o,
    output logic                      busy_o,
    output logic                      overflow_o,
    output logic                      protocol_err_o
);

    localparam int unsigned IDX_W  = $clog2(SIZE);
    localparam int unsigned ROWS_W = IDX_W + 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t                r_state;
    logic [ROWS_W-1:0]     r_rows_exp;
    logic [IDX_W-1:0]      r_row_cnt;
    logic                  r_tag;
    logic                  r_done;
    logic                  r_busy;
    logic                  r_ovf;
    logic                  r_perr;

    logic [PTR_W-1:0]      r_wr_ptr [SIZE];
    logic [PTR_W-1:0]      r_rd_ptr [SIZE];
    logic [CNT_W-1:0]      r_cnt    [SIZE];
    logic [DATA_WIDTH-1:0] r_mem    [SIZE][FIFO_DEPTH];

    logic [SIZE-1:0]       w_nonempty;
    logic [SIZE-1:0]       w_full;
    logic [SIZE-1:0]       w_push;
    logic [SIZE-1:0]       w_drop;
    logic                  w_row_valid;
    logic                  w_row_last;
    logic                  w_pop;

    // ---------------------------------------------------------------------
    // FIFO status, row qualification and push/drop decisions
    // ---------------------------------------------------------------------
    always_comb begin
        w_nonempty = '0;
        w_full     = '0;
        for (int i = 0; i < int'(SIZE); i++) begin
            w_nonempty[i] = (r_cnt[i] != '0);
            w_full[i]     = (r_cnt[i] == CNT_W'(FIFO_DEPTH));
        end

        // A row exists only once every lane has delivered its beat.
        w_row_valid = (r_state == S_COLLECT) && (&w_nonempty);
        w_row_last  = (ROWS_W'(r_row_cnt) == (r_rows_exp - ROWS_W'(1)));
        w_pop       = w_row_valid && row_ready_i;

        // A full lane still accepts a beat when the same cycle pops it.
        w_push = lane_valid_i & (~w_full | {SIZE{w_pop}});
        w_drop = lane_valid_i & w_full & {SIZE{~w_pop}};
    end

    // ---------------------------------------------------------------------
    // Lane FIFO pointers and occupancy
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SIZE); i++) begin
                r_wr_ptr[i] <= '0;
                r_rd_ptr[i] <= '0;
                r_cnt[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < int'(SIZE); i++) begin
                if (w_push[i]) begin
                    r_wr_ptr[i] <= r_wr_ptr[i] + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr[i] <= r_rd_ptr[i] + PTR_W'(1);
                end
                case ({w_push[i], w_pop})
                    2'b10:   r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                    2'b01:   r_cnt[i] <= r_cnt[i] - CNT_W'(1);
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
        end
    end

    // Lane FIFO storage; contents are don't-care until qualified by r_cnt.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(SIZE); i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wr_ptr[i]] <= data_in[i];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Tile control FSM with registered status outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rows_exp <= '0;
            r_row_cnt  <= '0;
            r_tag      <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            r_ovf      <= 1'b0;
            r_perr     <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (|w_drop) begin
                r_ovf <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (calc_done_i) begin
                        r_rows_exp <= ROWS_W'(valid_depth_i) + ROWS_W'(1);
                        r_tag      <= is_init_data_i;
                        r_row_cnt  <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_COLLECT;
                    end
                end

                S_COLLECT: begin
                    // A second announcement mid-tile is flagged and otherwise ignored.
                    if (calc_done_i) begin
                        r_perr <= 1'b1;
                    end
                    if (w_pop) begin
                        r_row_cnt <= r_row_cnt + IDX_W'(1);
                        if (w_row_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    if (calc_done_i) begin
                        r_perr <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Row outputs are zeroed whenever no row is qualified
    // ---------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < int'(SIZE); i++) begin
            row_data_o[i] = w_row_valid ? r_mem[i][r_rd_ptr[i]] : '0;
        end
    end

    assign row_valid_o    = w_row_valid;
    assign row_idx_o      = w_row_valid ? r_row_cnt : '0;
    assign row_last_o     = w_row_valid & w_row_last;
    assign is_init_data_o = r_tag;
    assign drain_done_o   = r_done;
    assign busy_o         = r_busy;
    assign overflow_o     = r_ovf;
    assign protocol_err_o = r_perr;

endmodule
